// File: rtl/clusterv_cfg_spi_target.sv
// clusterv_cfg_spi_target: oversampled config-SPI target (mode 0, 40-bit frames) driving a bank of 32-bit config registers.
module clusterv_cfg_spi_target #(
    parameter int N_REGS       = 8,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_sclk,
    input  logic                 cfg_sdo,
    output logic                 cfg_sdi,
    output logic [N_REGS*32-1:0] cfg_regs,
    output logic                 cfg_wr_stb,
    output logic [3:0]           cfg_wr_idx,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic [1:0]    sclk_sync, sdo_sync;
    logic          sclk_prev, rise, fall, hit, timeout;
    logic [5:0]    bit_cnt;
    logic [7:0]    cmd;
    logic [31:0]   rx_sr, tx_sr, rd_word, wr_word;
    logic [IW-1:0] idle_cnt;

    assign rise    = sclk_sync[1] & ~sclk_prev;
    assign fall    = ~sclk_sync[1] & sclk_prev;
    assign busy    = bit_cnt != '0;
    assign wr_word = {rx_sr[30:0], sdo_sync[1]};
    assign timeout = busy && !rise && !fall && idle_cnt == IW'(IDLE_TIMEOUT - 1);

    // out-of-range indices leave hit low, so reads return 0 and writes are dropped
    always_comb begin
        rd_word = '0;
        hit     = 1'b0;
        for (int i = 0; i < N_REGS; i++)
            if (cmd[3:0] == 4'(i)) begin
                rd_word = cfg_regs[32*i +: 32];
                hit     = 1'b1;
            end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync  <= '0;
            sdo_sync   <= '0;
            sclk_prev  <= 1'b0;
            bit_cnt    <= '0;
            cmd        <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            idle_cnt   <= '0;
            cfg_sdi    <= 1'b0;
            cfg_regs   <= '0;
            cfg_wr_stb <= 1'b0;
            cfg_wr_idx <= '0;
            frame_err  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], cfg_sclk};
            sdo_sync   <= {sdo_sync[0], cfg_sdo};
            sclk_prev  <= sclk_sync[1];
            cfg_wr_stb <= 1'b0;
            frame_err  <= 1'b0;
            if (rise) begin
                idle_cnt <= '0;
                if (bit_cnt < 6'd8)
                    cmd <= {cmd[6:0], sdo_sync[1]};
                else
                    rx_sr <= wr_word;
                if (bit_cnt == 6'd39) begin
                    bit_cnt <= '0;
                    cfg_sdi <= 1'b0;
                    if (cmd[7] && hit) begin
                        cfg_wr_stb <= 1'b1;
                        cfg_wr_idx <= cmd[3:0];
                        for (int i = 0; i < N_REGS; i++)
                            if (cmd[3:0] == 4'(i))
                                cfg_regs[32*i +: 32] <= wr_word;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end else if (fall) begin
                idle_cnt <= '0;
                // read data goes out on falls so the initiator samples it on the following rise
                if (!cmd[7] && bit_cnt == 6'd8) begin
                    cfg_sdi <= rd_word[31];
                    tx_sr   <= {rd_word[30:0], 1'b0};
                end else if (!cmd[7] && bit_cnt > 6'd8) begin
                    cfg_sdi <= tx_sr[31];
                    tx_sr   <= {tx_sr[30:0], 1'b0};
                end
            end else if (timeout) begin
                idle_cnt  <= '0;
                bit_cnt   <= '0;
                cfg_sdi   <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                idle_cnt <= busy ? idle_cnt + IW'(1) : '0;
            end
        end
    end
endmodule

// File: tb/tb_clusterv_cfg_spi_target.sv
// tb_clusterv_cfg_spi_target: randomized SPI initiator with scoreboarded write strobes and read-back words.
module tb_clusterv_cfg_spi_target;
    localparam int NR = 8;
    localparam int TO = 64;
    localparam int HP = 80;
    localparam int W  = NR * 32;

    logic         clock = 1'b0, reset = 1'b1, cfg_sclk = 1'b0, cfg_sdo = 1'b0;
    logic         cfg_sdi, cfg_wr_stb, frame_err, busy;
    logic [W-1:0] cfg_regs;
    logic [3:0]   cfg_wr_idx;

    clusterv_cfg_spi_target #(.N_REGS(NR), .IDLE_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .cfg_sclk(cfg_sclk), .cfg_sdo(cfg_sdo),
        .cfg_sdi(cfg_sdi), .cfg_regs(cfg_regs), .cfg_wr_stb(cfg_wr_stb),
        .cfg_wr_idx(cfg_wr_idx), .frame_err(frame_err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]   idx;
        logic [W-1:0] bank;
    } wr_t;

    int          checks = 0, errors = 0, err_seen = 0;
    logic [31:0] model [16];
    wr_t         exp_wr [$];
    logic [39:0] exp_rd [$];
    logic [39:0] obs_rd [$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] bank_of();
        logic [W-1:0] b;
        for (int i = 0; i < NR; i++) b[32*i +: 32] = model[i];
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    // Initiator: mode 0, MSB first; samples cfg_sdi on each rising sclk edge.
    task automatic frame(input logic [7:0] c, input logic [31:0] d, input int nbits);
        logic [39:0] f, cap;
        f   = {c, d};
        cap = '0;
        if (nbits == 40) begin
            if (c[7]) begin
                if (int'(c[3:0]) < NR) begin
                    model[c[3:0]] = d;
                    exp_wr.push_back('{c[3:0], bank_of()});
                end
                exp_rd.push_back(40'h0);
            end else begin
                exp_rd.push_back({8'h0, int'(c[3:0]) < NR ? model[c[3:0]] : 32'h0});
            end
        end
        for (int k = 0; k < nbits; k++) begin
            cfg_sdo = f[39-k];
            #HP;
            cfg_sclk = 1'b1;
            cap = {cap[38:0], cfg_sdi};
            #HP;
            cfg_sclk = 1'b0;
        end
        if (nbits == 40) obs_rd.push_back(cap);
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (frame_err) err_seen++;
        if (cfg_wr_stb) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected idx=%0d exp=none", cfg_wr_idx);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_idx", W'(cfg_wr_idx), W'(e.idx));
                chk("wr_bank", cfg_regs, e.bank);
            end
        end
        if (obs_rd.size() > 0 && exp_rd.size() > 0)
            chk("sdi_frame", W'(obs_rd.pop_front()), W'(exp_rd.pop_front()));
    end

    initial begin
        #900_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        for (int i = 0; i < 16; i++) model[i] = '0;
        idle(3);
        reset = 1'b0;
        idle(3);
        chk("rst_regs", cfg_regs, '0);
        chk("rst_sdi", W'(cfg_sdi), '0);
        chk("rst_stb", W'(cfg_wr_stb), '0);
        chk("rst_idx", W'(cfg_wr_idx), '0);
        chk("rst_err", W'(frame_err), '0);
        chk("rst_busy", W'(busy), '0);

        frame(8'h83, 32'hCAFEF00D, 40);
        idle(4);
        frame(8'h03, $urandom, 40);
        idle(6);
        chk("sdi_after_read", W'(cfg_sdi), '0);

        frame(8'h8A, 32'h12345678, 40);
        idle(4);
        frame(8'h0A, $urandom, 40);
        idle(4);
        chk("bank_after_oor", cfg_regs, bank_of());

        frame(8'h85, $urandom, 20);
        chk("busy_partial", W'(busy), W'(1'b1));
        idle(TO + 12);
        chk("busy_timeout", W'(busy), '0);
        chk("err_timeout", W'(err_seen), W'(1));
        frame(8'h81, 32'h00000055, 40);
        idle(4);
        chk("reg1_after_timeout", W'(cfg_regs[63:32]), W'(32'h55));

        frame(8'h80, 32'hA5A5A5A5, 40);
        frame(8'h00, $urandom, 40);
        idle(4);

        frame(8'h82, 32'h0BADBEEF, 25);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        idle(3);
        reset = 1'b0;
        idle(3);
        chk("busy_after_rst", W'(busy), '0);
        chk("regs_after_rst", cfg_regs, '0);
        frame(8'h82, 32'h600DF00D, 40);
        idle(4);
        chk("reg2_after_rst", W'(cfg_regs[95:64]), W'(32'h600DF00D));

        for (int n = 0; n < 40; n++) begin
            c = {1'($urandom), 3'($urandom), 4'($urandom_range(0, 11))};
            frame(c, $urandom, 40);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
        end

        idle(20);
        chk("sdi_final", W'(cfg_sdi), '0);
        chk("err_count", W'(err_seen), W'(1));
        chk("bank_final", cfg_regs, bank_of());
        chk("wr_queue_empty", W'(exp_wr.size()), '0);
        chk("rd_queue_empty", W'(exp_rd.size() + obs_rd.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clusterv_cfg_spi_target.md
# clusterv_cfg_spi_target

Configuration-SPI target on the cluster side of the management link. It consumes the `cfg_sclk`/`cfg_sdo` serial stream produced by the management interface's config SPI initiator and returns read data on `cfg_sdi`. It maintains a bank of 32-bit configuration registers that drive cluster-side control inputs. The SPI pins are oversampled in a single local clock domain; there is no chip select, so framing uses a fixed frame length plus an idle timeout.

## Interface
Parameters:
- `N_REGS`, 8: number of 32-bit config registers (1..16).
- `IDLE_TIMEOUT`, 64: clocks without any sclk edge after which a partial frame is discarded (≥4).

Ports:
- `clock`  in  1  block clock; must run ≥8× the sclk frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_sclk`  in  1  SPI clock from the initiator (asynchronous to `clock`).
- `cfg_sdo`  in  1  SPI MOSI from the initiator.
- `cfg_sdi`  out  1  SPI MISO to the initiator.
- `cfg_regs`  out  N_REGS*32  flattened register bank; reg i is at `[32*i+31:32*i]`.
- `cfg_wr_stb`  out  1  one-clock pulse when a register is written.
- `cfg_wr_idx`  out  4  index of the register written; valid while `cfg_wr_stb` is high.
- `frame_err`  out  1  one-clock pulse when a partial frame is discarded.
- `busy`  out  1  high while a frame is in progress (bit count ≠ 0).

## Operation
- Synchronisation: `cfg_sclk` and `cfg_sdo` each pass through a 2-flop synchroniser. A third sclk flop provides edge detection: rise = sync & ~prev, fall = ~sync & prev. `cfg_sdo` is sampled from its synchronised value on a detected rise.
- SPI mode 0, MSB first. Frame = 40 bits: 8-bit command, then 32-bit data.
- Command byte: bit7 = 1 for write, 0 for read; bits[6:4] are ignored; bits[3:0] = register index.
- Bit counter `bit_cnt` (0..39) advances on each detected rise.
- Write frame: data bits shift into `rx_sr`. On the 40th rise:
  - if idx < N_REGS: reg[idx] ← `rx_sr`, `cfg_wr_stb` = 1, `cfg_wr_idx` = idx, all for one clock;
  - if idx ≥ N_REGS: the write is ignored and no strobe is issued;
  - `bit_cnt` returns to 0.
- Read frame: on the first fall after the 8th rise, `tx_sr` loads reg[idx] (0 if idx ≥ N_REGS) and `cfg_sdi` ← bit 31. Each subsequent fall shifts `tx_sr` left and drives the next bit. After the 40th rise, `cfg_sdi` is 0.
- `cfg_sdi` is 0 during the command phase and throughout write frames.
- Timeout: while `busy`, an idle counter increments each clock and clears on any detected edge. At `IDLE_TIMEOUT`: `bit_cnt` ← 0, `cfg_sdi` ← 0, `frame_err` pulses for one clock, and no register changes. The idle counter holds at 0 when not busy.
- Back-to-back frames need no gap: the 41st rise is bit 0 of the next frame.

## Timing
- Reset values: `cfg_regs` all 0, `cfg_sdi` 0, `cfg_wr_stb` 0, `cfg_wr_idx` 0, `frame_err` 0, `busy` 0. Internal counters and shift registers are also 0.
- Reset mid-frame discards the frame immediately. The next rise after reset deasserts is treated as bit 0.
- Latency from a pin sclk edge to the detected edge: 3 clocks (2 synchroniser + 1 edge).
- `cfg_regs` and `cfg_wr_stb` update in the same clock, 1 clock after the 40th detected rise.
- `cfg_sdi` updates 1 clock after the detected fall, i.e. ≤4 clocks after the pin falling edge. At ≥8× oversampling it is settled before the next pin rising edge.
- A rise and a fall are never detected in the same clock.
- A write completing in the same clock as the timeout cannot occur: the completing edge clears the idle counter.

## Test plan
- Write: frame 0x83 + 0xCAFEF00D → reg3 = 0xCAFEF00D; `cfg_wr_stb` pulses for 1 clock with `cfg_wr_idx` = 3; other registers unchanged.
- Read-back: after the write above, frame 0x03 + 32 dummy bits → the initiator samples 0xCAFEF00D on `cfg_sdi`; `cfg_sdi` is 0 during the command byte and after the frame.
- Out of range (N_REGS = 8): write 0x8A + 0x12345678 → no `cfg_wr_stb`, bank unchanged; read 0x0A → data 0x00000000.
- Timeout: send 20 bits, then hold sclk for IDLE_TIMEOUT clocks → `frame_err` pulses once and `busy` drops. A following full write 0x81 + 0x00000055 sets reg1 = 0x55.
- Back-to-back: write reg0 = 0xA5A5A5A5, then read reg0 with no gap → read returns 0xA5A5A5A5 and two frames are counted correctly.
- Reset mid-frame: assert `reset` at bit 25 of a write to reg2 → reg2 stays 0 and `busy` goes to 0. A subsequent complete write succeeds.
